spi_slave_if: RTL and testbench



---
 rtl/spi_slave_if.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_if.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
// spi_slave_if: oversampled SPI responder. Deframes 32-bit words while
// spi_frame is low and, when SPI_SLAVE_OOB_EN is defined, single out-of-band
// bytes while spi_frame is high. Reply data comes from a one-entry hold
// register; an empty hold at unit start sends TX_IDLE and flags tx_underrun.
module spi_slave_if #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TX_IDLE     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_cs,
  input  logic        spi_frame,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_oob,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_underrun,
  output logic        frame_err
);

`ifdef SPI_SLAVE_OOB_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, frame_sync;
  logic        sclk_prev, cs_prev, frame_prev;
  logic        sclk_s, mosi_s, cs_s, frame_s;
  logic        sclk_rise, cs_fall, cs_rise, frame_edge;
  logic [1:0]  state;
  logic [5:0]  bit_cnt;
  logic [5:0]  unit_len;
  logic        shift_en, done;
  logic [31:0] rx_sh, tx_sh;
  logic [31:0] hold;
  logic        hold_valid;
  logic [31:0] load_word;

  // Synchronize the SPI pins and keep one previous sample for edge detection.
  // cs resets to its deasserted (high) level so reset release is not a cs fall.
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample pre-edge values; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      cs_sync    <= '1;
      frame_sync <= '0;
      sclk_prev  <= 1'b0;
      cs_prev    <= 1'b1;
      frame_prev <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      frame_sync <= {frame_sync[SYNC_STAGES-2:0], spi_frame};
      sclk_prev  <= sclk_s;
      cs_prev    <= cs_s;
      frame_prev <= frame_s;
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign frame_s    = frame_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev;
  assign cs_fall    = cs_prev & ~cs_s;
  assign cs_rise    = ~cs_prev & cs_s;
  assign frame_edge = frame_s ^ frame_prev;

  // Without OOB support, bits clocked while spi_frame is high are ignored.
  assign unit_len  = (OOB_EN && frame_s) ? 6'd8 : 6'd32;
  assign shift_en  = OOB_EN || !frame_s;
  assign done      = (state == ST_SHIFT) && (bit_cnt == unit_len);
  assign load_word = hold_valid ? hold : TX_IDLE;
  assign tx_ready  = !hold_valid;

  // Unit sequencer: IDLE -> LOAD -> SHIFT -> LOAD ... while cs stays low.
  // The frame-edge and cs-rise handling after the case statement deliberately
  // overrides the case result; cs rise is last so it wins over a frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_oob      <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) state <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_sh       <= load_word;
          tx_underrun <= !hold_valid;
          rx_sh       <= '0;
          bit_cnt     <= '0;
          state       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (done) begin
            rx_valid <= 1'b1;
            rx_oob   <= OOB_EN && frame_s;
            rx_data  <= (OOB_EN && frame_s) ? {24'h0, rx_sh[31:24]} : rx_sh;
            bit_cnt  <= '0;
            state    <= ST_LOAD;
          end else if (sclk_rise && shift_en) begin
            rx_sh   <= {mosi_s, rx_sh[31:1]};
            tx_sh   <= {1'b0, tx_sh[31:1]};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (frame_edge && !cs_s && state != ST_IDLE) begin
        if (OOB_EN) begin
          frame_err <= (bit_cnt != 6'd0) && !done;
          state     <= ST_LOAD;
        end
        bit_cnt <= '0;
      end

      if (cs_rise) begin
        frame_err <= (state == ST_SHIFT) && (bit_cnt != 6'd0) && !done;
        bit_cnt   <= '0;
        state     <= ST_IDLE;
      end
    end
  end

  // One-entry reply hold: LOAD empties it, and a write in the same cycle as
  // LOAD lands afterwards (later non-blocking assignment wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (state == ST_LOAD) hold_valid <= 1'b0;
      if (tx_valid && tx_ready) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end
    end
  end

  // Drive MISO from the low bit of the reply shifter, one cycle behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_miso <= 1'b0;
    end else if (state == ST_IDLE || !shift_en) begin
      spi_miso <= 1'b0;
    end else if (state == ST_LOAD) begin
      spi_miso <= load_word[0];
    end else begin
      spi_miso <= tx_sh[0];
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
`timescale 1ns/1ps
// tb_spi_slave_if: directed bench for spi_slave_if with a bit-banged SPI
// master (LSB first, 20 ns half period) and a 200 MHz system clock.
module tb_spi_slave_if;

  localparam int DLY = 20;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        spi_clk   = 1'b0;
  logic        spi_mosi  = 1'b0;
  logic        spi_cs    = 1'b1;
  logic        spi_frame = 1'b0;
  logic [31:0] tx_data   = '0;
  logic        tx_valid  = 1'b0;
  logic        spi_miso;
  logic [31:0] rx_data;
  logic        rx_valid, rx_oob, tx_ready, tx_underrun, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int und_cnt  = 0;
  int ferr_cnt = 0;
  logic [32:0] rx_q[$];

  spi_slave_if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_cs     (spi_cs),
    .spi_frame  (spi_frame),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_oob     (rx_oob),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .frame_err  (frame_err)
  );

  always #2.5 clk = ~clk;

  // Record output pulses away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back({rx_oob, rx_data});
    if (tx_underrun) und_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] rx_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return {33{1'bx}};
  endfunction

  task automatic hold_write(input logic [31:0] v);
    @(negedge clk);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Wait (bounded) for an empty hold register, then refill it.
  task automatic feed(input logic [31:0] v);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("feed_ready", {31'b0, tx_ready}, 32'h1);
    hold_write(v);
  endtask

  // Master: drive MOSI, raise SCLK and sample MISO, lower SCLK; LSB first.
  task automatic spi_unit(input logic [31:0] w, input int nbits, output logic [31:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = w[i];
      #(DLY);
      spi_clk = 1'b1;
      r[i] = spi_miso;
      #(DLY);
      spi_clk = 1'b0;
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1, r2;
    logic [32:0] e;
    int rb, ub, fb;

    // Reset values
    #12;
    check("rst_miso",     {31'b0, spi_miso},    32'h0);
    check("rst_rx_valid", {31'b0, rx_valid},    32'h0);
    check("rst_rx_oob",   {31'b0, rx_oob},      32'h0);
    check("rst_underrun", {31'b0, tx_underrun}, 32'h0);
    check("rst_frame_err",{31'b0, frame_err},   32'h0);
    check("rst_rx_data",  rx_data,              32'h0);
    check("rst_tx_ready", {31'b0, tx_ready},    32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single word with preloaded reply
    hold_write(32'h89AB_CDEF);
    check("word_ready_full", {31'b0, tx_ready}, 32'h0);
    rb = rx_q.size();
    ub = und_cnt;
    spi_cs = 1'b0;
    #(2*DLY);
    check("word_ready_after_load", {31'b0, tx_ready}, 32'h1);
    check("word_no_underrun", 32'(und_cnt - ub), 32'h0);
    spi_unit(32'h1234_5678, 32, r0);
    #(2*DLY); spi_cs = 1'b1; #(4*DLY);
    check("word_rx_count", 32'(rx_q.size() - rb), 32'h1);
    e = rx_at(rb);
    check("word_rx_data", e[31:0], 32'h1234_5678);
    check("word_rx_oob", {31'b0, e[32]}, 32'h0);
    check("word_reply", r0, 32'h89AB_CDEF);

    // Three back-to-back words, hold refilled each time it empties
    hold_write(32'h11);
    rb = rx_q.size();
    spi_cs = 1'b0;
    #(2*DLY);
    fork
      begin
        feed(32'h22);
        feed(32'h33);
      end
      begin
        spi_unit(32'h0000_0001, 32, r0);
        spi_unit(32'hFFFF_FFFE, 32, r1);
        spi_unit(32'hA5A5_5A5A, 32, r2);
      end
    join
    #(2*DLY); spi_cs = 1'b1; #(4*DLY);
    check("b2b_rx_count", 32'(rx_q.size() - rb), 32'h3);
    e = rx_at(rb);     check("b2b_rx0", e[31:0], 32'h0000_0001);
    e = rx_at(rb + 1); check("b2b_rx1", e[31:0], 32'hFFFF_FFFE);
    e = rx_at(rb + 2); check("b2b_rx2", e[31:0], 32'hA5A5_5A5A);
    check("b2b_reply0", r0, 32'h11);
    check("b2b_reply1", r1, 32'h22);
    check("b2b_reply2", r2, 32'h33);

    // Underrun: hold empty at unit start
    rb = rx_q.size();
    ub = und_cnt;
    spi_cs = 1'b0;
    #(2*DLY);
    check("undr_pulse", 32'(und_cnt - ub), 32'h1);
    spi_unit(32'hCAFE_F00D, 32, r0);
    #(2*DLY); spi_cs = 1'b1; #(4*DLY);
    check("undr_reply", r0, 32'hFFFF_FFFF);
    check("undr_rx_count", 32'(rx_q.size() - rb), 32'h1);
    e = rx_at(rb);
    check("undr_rx_data", e[31:0], 32'hCAFE_F00D);

    // Out-of-band bytes (frame high)
`ifdef SPI_SLAVE_OOB_EN
    spi_frame = 1'b1;
    #(2*DLY);
    hold_write(32'h5A);
    rb = rx_q.size();
    spi_cs = 1'b0;
    #(2*DLY);
    fork
      feed(32'hA5);
      begin
        spi_unit(32'h3C, 8, r0);
        spi_unit(32'hC3, 8, r1);
      end
    join
    #(2*DLY); spi_cs = 1'b1; #(2*DLY); spi_frame = 1'b0; #(2*DLY);
    check("oob_rx_count", 32'(rx_q.size() - rb), 32'h2);
    e = rx_at(rb);
    check("oob_rx0", e[31:0], 32'h3C);
    check("oob_flag0", {31'b0, e[32]}, 32'h1);
    e = rx_at(rb + 1);
    check("oob_rx1", e[31:0], 32'hC3);
    check("oob_flag1", {31'b0, e[32]}, 32'h1);
    check("oob_reply0", r0, 32'h5A);
    check("oob_reply1", r1, 32'hA5);
`else
    spi_frame = 1'b1;
    #(2*DLY);
    rb = rx_q.size();
    fb = ferr_cnt;
    spi_cs = 1'b0;
    #(2*DLY);
    spi_unit(32'h3C, 8, r0);
    #(2*DLY); spi_cs = 1'b1; #(2*DLY); spi_frame = 1'b0; #(2*DLY);
    check("oob_off_rx_count", 32'(rx_q.size() - rb), 32'h0);
    check("oob_off_miso", r0, 32'h0);
    check("oob_off_ferr", 32'(ferr_cnt - fb), 32'h0);
`endif

    // Frame edge after two bytes of a word, then a full word
    rb = rx_q.size();
    fb = ferr_cnt;
    spi_cs = 1'b0;
    #(2*DLY);
    spi_unit(32'hDEAD_BEEF, 16, r0);
    spi_frame = 1'b1; #(4*DLY);
    spi_frame = 1'b0; #(4*DLY);
    check("trunc_no_rx", 32'(rx_q.size() - rb), 32'h0);
`ifdef SPI_SLAVE_OOB_EN
    check("trunc_frame_err", 32'(ferr_cnt - fb), 32'h1);
`else
    check("trunc_frame_err", 32'(ferr_cnt - fb), 32'h0);
`endif
    spi_unit(32'h0BAD_F00D, 32, r0);
    #(2*DLY); spi_cs = 1'b1; #(4*DLY);
    check("trunc_rx_count", 32'(rx_q.size() - rb), 32'h1);
    e = rx_at(rb);
    check("trunc_rx_data", e[31:0], 32'h0BAD_F00D);

    // cs rise after one byte of a word
    rb = rx_q.size();
    fb = ferr_cnt;
    spi_cs = 1'b0;
    #(2*DLY);
    spi_unit(32'hFF, 8, r0);
    #(2*DLY); spi_cs = 1'b1; #(4*DLY);
    check("csrise_frame_err", 32'(ferr_cnt - fb), 32'h1);
    check("csrise_no_rx", 32'(rx_q.size() - rb), 32'h0);

    // Reset in the middle of a word with the hold register full
    spi_cs = 1'b0;
    #(2*DLY);
    hold_write(32'h7777_7777);
    check("mid_rst_hold_full", {31'b0, tx_ready}, 32'h0);
    spi_unit(32'h3FF, 10, r0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso",     {31'b0, spi_miso},    32'h0);
    check("mid_rst_rx_valid", {31'b0, rx_valid},    32'h0);
    check("mid_rst_rx_data",  rx_data,              32'h0);
    check("mid_rst_tx_ready", {31'b0, tx_ready},    32'h1);
    check("mid_rst_ferr",     {31'b0, frame_err},   32'h0);
    check("mid_rst_underrun", {31'b0, tx_underrun}, 32'h0);
    spi_cs = 1'b1;
    #(4*DLY);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    hold_write(32'h1357_9BDF);
    rb = rx_q.size();
    spi_cs = 1'b0;
    #(2*DLY);
    spi_unit(32'h600D_CAFE, 32, r0);
    #(2*DLY); spi_cs = 1'b1; #(4*DLY);
    check("post_rst_rx_count", 32'(rx_q.size() - rb), 32'h1);
    e = rx_at(rb);
    check("post_rst_rx_data", e[31:0], 32'h600D_CAFE);
    check("post_rst_reply", r0, 32'h1357_9BDF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
